store_buffer: RTL and testbench
===============================

# store_buffer

Posted-store buffer between the EX/MEM pipeline register and the single-port `data_memory`. Stores are queued in a small FIFO and retire to memory one per cycle whenever the memory port is not needed by a load, so a store never holds the MEM stage. Loads read memory combinationally in the same cycle and see pending stores through forwarding or, when forwarding is compiled out, through a stall.

## Interface
- `DEPTH`, 4: number of buffered stores; a power of two, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `st_valid` in 1: a store instruction is in MEM this cycle.
- `st_addr` in ADDR_W, `st_data` in DATA_W: store address and data.
- `ld_valid` in 1: a load instruction is in MEM this cycle.
- `ld_addr` in ADDR_W: load address.
- `ld_data` out DATA_W: load result to MEM/WB.
- `ld_hit` out 1: `ld_data` was forwarded from the buffer.
- `stall` out 1: to the hazard unit; freezes IF through MEM this cycle.
- `mem_write` out 1, `mem_address` out ADDR_W, `mem_write_data` out DATA_W: drive `data_memory`.
- `mem_read_data` in DATA_W: from `data_memory`.
- `count` out clog2(DEPTH+1): number of occupied entries.

## Operation
- `data_memory` contract: the write lands on the rising edge when `mem_write`=1; reads are combinational from `mem_address`.
- **FIFO.** Entries are {addr, data}, held with head/tail pointers that wrap modulo DEPTH.
  - `full` = (`count`==DEPTH).
  - A push is accepted when `st_valid` && !`full`.
- **Forced drain.** `force_drain` = `full` || (`ld_valid` && `conflict`).
  - `conflict` is 0 when STORE_FWD_EN is defined.
  - Otherwise `conflict` = any valid entry whose addr[ADDR_W-1:2] equals ld_addr[ADDR_W-1:2].
- **Port arbitration, each cycle:**
  - If `ld_valid` && !`force_drain`: the port serves the load. `mem_address`=`ld_addr`, `mem_write`=0.
  - Else if `count`>0: drain the head. `mem_write`=1, `mem_address`/`mem_write_data` = head entry; the head pops at the edge.
  - Else: idle. `mem_write`=0, `mem_address`=`ld_addr`.
- **Stall.** `stall` = (`st_valid` && `full`) || (`ld_valid` && `force_drain`).
  - A stalled store is not accepted; the load result is ignored by MEM/WB.
  - The instruction repeats next cycle.
- **Load data.** `ld_data` = `mem_read_data`, unless a forwarding hit occurs (see Configuration).
- **Simultaneous push and pop:** allowed when not full; `count` is unchanged.
- **`st_valid` and `ld_valid` both high:** illegal, since the MEM stage holds one instruction. The block accepts the store, asserts `stall`, and drives `ld_hit`=0.
- **Reset:** all pending stores are discarded.

## Timing
- Reset values: `count`=0, pointers=0, `mem_write`=0, `ld_hit`=0, `stall`=0, `ld_data`=`mem_read_data`.
- Latency:
  - A store pushed at edge N is drainable in cycle N+1 and visible in memory after edge N+1 at the earliest.
  - Load data is combinational in the same cycle, with zero added latency.
- One drain per cycle at most; a full buffer with continuous loads drains one entry per cycle.
- A non-forwarding conflict stalls the load for at most DEPTH cycles.
- A `reset` asserted during a drain cycle suppresses that write.

## Configuration
- `STORE_FWD_EN` defined:
  - Loads compare against all valid entries.
  - The youngest matching entry drives `ld_data` with `ld_hit`=1, in the same cycle.
  - Loads never stall on address conflicts.
- `STORE_FWD_EN` undefined:
  - There is no comparator data path, and `ld_hit` is tied to 0.
  - Conflicting loads force drains and stall until no entry matches.

## Structure
- Shared package `mem_pkg`: `ADDR_W`, `DATA_W`, the `sb_entry_t` {addr, data} typedef, and the word-compare helper.
- Sub-module `sb_match`:
  - Per-entry word-address compare, masked by entry validity.
  - Youngest-first priority relative to the tail pointer.
  - Outputs `any_match` and `match_idx`.
  - Instantiated in both configurations.

## Test plan
- **Empty buffer load.** After reset, load addr 12 (memory holds 3) -> `ld_data`=3, `ld_hit`=0, `stall`=0, `mem_write`=0.
- **Idle drain.** Store (20, 0), then idle -> next cycle `mem_write`=1, addr 20, data 0; then `count`=0. A load of 20 afterwards returns 0.
- **Store then load, same address.** Store (20, 7), then load 20 in the next cycle:
  - FWD: `ld_hit`=1, `ld_data`=7, `stall`=0.
  - No FWD: `stall`=1 for one cycle while 20 is written, then `ld_data`=7.
- **Youngest wins.** Stores (20, 9) then (20, 11), with loads of 12 blocking the drain; then load 20 -> FWD returns 11; no FWD returns 11 after both drain.
- **Full buffer.** Four stores, each followed by a load of 12 -> `count`=4. A fifth store gives `stall`=1 for one cycle while the head drains, then it is accepted.
- **Reset mid-operation.** Reset with 3 pending stores -> `count`=0, no further `mem_write`, and memory at 20 still reads 5.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-side types for the store buffer: bus widths, the buffered
// entry layout and the word-address compare used for load/store matching.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  // Byte offset bits are ignored: two accesses collide when they touch the same word.
  function automatic logic same_word(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:2] == b[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline and data_memory signals seen by the store buffer. The slave side is
// the buffer itself; the master side is the MEM stage plus data_memory.
interface store_buffer_if import mem_pkg::*; #(
  parameter int DEPTH = 4
);

  logic                           st_valid;
  logic [ADDR_W-1:0]              st_addr;
  logic [DATA_W-1:0]              st_data;
  logic                           ld_valid;
  logic [ADDR_W-1:0]              ld_addr;
  logic [DATA_W-1:0]              ld_data;
  logic                           ld_hit;
  logic                           stall;
  logic                           mem_write;
  logic [ADDR_W-1:0]              mem_address;
  logic [DATA_W-1:0]              mem_write_data;
  logic [DATA_W-1:0]              mem_read_data;
  logic [$clog2(DEPTH+1)-1:0]     count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
    input  ld_data, ld_hit, stall, mem_write, mem_address, mem_write_data, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
    output ld_data, ld_hit, stall, mem_write, mem_address, mem_write_data, count
  );

endinterface

// File: rtl/sb_match.sv
// Compares a load address against every valid buffered store and reports the
// youngest matching entry, scanning backwards from the tail pointer.
module sb_match import mem_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic [ADDR_W-1:0]          entry_addr [DEPTH],
  input  logic [DEPTH-1:0]           entry_valid,
  input  logic [$clog2(DEPTH)-1:0]   tail,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       any_match,
  output logic [$clog2(DEPTH)-1:0]   match_idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] hit;
  logic [PTR_W-1:0] idx;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign hit[gi] = entry_valid[gi] && same_word(entry_addr[gi], ld_addr);
    end
  endgenerate

  // Oldest slot visited first so the youngest hit (tail-1) is written last.
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    idx       = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (hit[idx]) begin
        any_match = 1'b1;
        match_idx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of single-port data_memory; stores drain whenever
// no load needs the port. STORE_FWD_EN selects load forwarding instead of stalls.
module store_buffer import mem_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t         entry_reg [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [PTR_W-1:0]  offset [DEPTH];
  logic [DEPTH-1:0]  entry_valid;
  logic              any_match;
  logic [PTR_W-1:0]  match_idx;
  logic              full, conflict, force_drain, serve_load, drain, push;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign entry_addr[gi]  = entry_reg[gi].addr;
      assign offset[gi]      = PTR_W'(gi) - head_reg;
      assign entry_valid[gi] = CNT_W'(offset[gi]) < count_reg;
    end
  endgenerate

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid),
    .tail        (tail_reg),
    .ld_addr     (bus.ld_addr),
    .any_match   (any_match),
    .match_idx   (match_idx)
  );

  assign full = (count_reg == CNT_W'(DEPTH));
`ifdef STORE_FWD_EN
  assign conflict = 1'b0;
`else
  assign conflict = any_match;
`endif
  assign force_drain = full || (bus.ld_valid && conflict);
  assign serve_load  = bus.ld_valid && !force_drain;
  // Reset blocks the drain so a write in flight never reaches memory.
  assign drain       = !reset && !serve_load && (count_reg != '0);
  assign push        = !reset && bus.st_valid && !full;

  assign bus.mem_write      = drain;
  assign bus.mem_address    = drain ? entry_reg[head_reg].addr : bus.ld_addr;
  assign bus.mem_write_data = entry_reg[head_reg].data;
  assign bus.count          = count_reg;
  assign bus.stall          = !reset && ((bus.st_valid && full) ||
                                         (bus.ld_valid && force_drain) ||
                                         (bus.st_valid && bus.ld_valid));

`ifdef STORE_FWD_EN
  logic fwd_hit;
  assign fwd_hit     = !reset && bus.ld_valid && !bus.st_valid && any_match;
  assign bus.ld_hit  = fwd_hit;
  assign bus.ld_data = fwd_hit ? entry_reg[match_idx].data : bus.mem_read_data;
`else
  logic unused_match_idx;
  assign unused_match_idx = ^match_idx;
  assign bus.ld_hit  = 1'b0;
  assign bus.ld_data = bus.mem_read_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        entry_reg[tail_reg] <= sb_entry_t'{addr: bus.st_addr, data: bus.st_data};
        tail_reg            <= tail_reg + 1'b1;
      end
      if (drain) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, drain})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed plus random stimulus for store_buffer, checked cycle by cycle against
// a queue-based model of pending stores and the memory contents they produce.
module tb_store_buffer;

  localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  store_buffer_if #(.DEPTH(DEPTH)) sbif ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sbif)
  );

  always #5 clk = ~clk;

  logic [31:0] env_mem [64];
  logic [31:0] ref_mem [64];
  ent_t        q [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  logic        s_stall, s_hit, s_mw;
  logic [31:0] s_addr, s_wdata, s_ld_data;
  logic [2:0]  s_count;

  assign sbif.mem_read_data = env_mem[sbif.mem_address[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0:       b = 32'd12;
      1:       b = 32'd16;
      2:       b = 32'd20;
      default: b = 32'd24;
    endcase
    if ($urandom_range(0, 3) == 0) b = b + 32'($urandom_range(1, 3));
    return b;
  endfunction

  // One clock: drive, compare at the falling edge, then advance the model.
  task automatic cycle(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    logic full, found, fd, serve, drain, e_stall, e_hit;
    logic [31:0] fdata, e_addr, e_ld;
    int sz;
    reset = r;
    sbif.st_valid = sv; sbif.st_addr = sa; sbif.st_data = sd;
    sbif.ld_valid = lv; sbif.ld_addr = la;
    #4;
    sz = q.size();
    full = (sz == DEPTH);
    found = 1'b0;
    fdata = '0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (q[i].a[31:2] == la[31:2]) begin
        found = 1'b1;
        fdata = q[i].d;
        break;
      end
    end
    fd      = full || (!FWD && lv && found);
    serve   = lv && !fd;
    drain   = !r && !serve && (sz > 0);
    e_stall = !r && ((sv && full) || (lv && fd) || (sv && lv));
    e_hit   = FWD && !r && lv && !sv && found;
    e_addr  = la;
    if (drain) e_addr = q[0].a;
    e_ld    = e_hit ? fdata : ref_mem[e_addr[7:2]];

    s_stall = sbif.stall; s_hit = sbif.ld_hit; s_mw = sbif.mem_write;
    s_addr = sbif.mem_address; s_wdata = sbif.mem_write_data;
    s_ld_data = sbif.ld_data; s_count = sbif.count;

    check("count", 32'(s_count), 32'(sz));
    check("stall", 32'(s_stall), 32'(e_stall));
    check("ld_hit", 32'(s_hit), 32'(e_hit));
    check("mem_write", 32'(s_mw), 32'(drain));
    check("mem_address", s_addr, e_addr);
    check("ld_data", s_ld_data, e_ld);
    if (drain) check("mem_write_data", s_wdata, q[0].d);
    $display("cyc %0d rst=%0b st=%0b %0h/%0h ld=%0b %0h -> stall=%0b hit=%0b ld_data=%0h mw=%0b addr=%0h cnt=%0d",
             cyc, r, sv, sa, sd, lv, la, s_stall, s_hit, s_ld_data, s_mw, s_addr, s_count);
    cyc++;

    @(posedge clk);
    if (s_mw) env_mem[s_addr[7:2]] = s_wdata;
    if (r) begin
      q.delete();
    end else begin
      if (drain) begin
        ref_mem[q[0].a[7:2]] = q[0].d;
        void'(q.pop_front());
      end
      if (sv && !full) q.push_back('{a: sa, d: sd});
    end
    #1;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (s_count == 0) break;
    end
    check("drain_all_empty", 32'(q.size()), 0);
  endtask

  initial begin : stim
    bit done;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 32'(i);
      ref_mem[i] = 32'(i);
    end
    reset = 1'b1;
    sbif.st_valid = 1'b0; sbif.st_addr = '0; sbif.st_data = '0;
    sbif.ld_valid = 1'b0; sbif.ld_addr = 32'd12;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    cycle(1, 0, 0, 0, 1, 12);
    check("rst_count", 32'(s_count), 0);
    check("rst_mem_write", 32'(s_mw), 0);
    check("rst_stall", 32'(s_stall), 0);
    check("rst_ld_hit", 32'(s_hit), 0);
    check("rst_ld_data", s_ld_data, 3);

    // empty buffer load
    cycle(0, 0, 0, 0, 1, 12);
    check("empty_ld_data", s_ld_data, 3);
    check("empty_stall", 32'(s_stall), 0);
    check("empty_mem_write", 32'(s_mw), 0);

    // reset with three pending stores
    cycle(0, 1, 20, 100, 1, 12);
    cycle(0, 1, 20, 101, 1, 12);
    cycle(0, 1, 20, 102, 1, 12);
    cycle(0, 0, 0, 0, 1, 12);
    check("pend3_count", 32'(s_count), 3);
    cycle(1, 0, 0, 0, 0, 12);
    check("rst_drain_suppressed", 32'(s_mw), 0);
    cycle(0, 0, 0, 0, 0, 12);
    check("post_rst_count", 32'(s_count), 0);
    check("post_rst_mem_write", 32'(s_mw), 0);
    cycle(0, 0, 0, 0, 1, 20);
    check("post_rst_mem20", s_ld_data, 5);

    // idle drain
    cycle(0, 1, 20, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("idle_drain_we", 32'(s_mw), 1);
    check("idle_drain_addr", s_addr, 20);
    check("idle_drain_data", s_wdata, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("idle_drain_count", 32'(s_count), 0);
    cycle(0, 0, 0, 0, 1, 20);
    check("idle_drain_load", s_ld_data, 0);

    // store then load same address
    cycle(0, 1, 20, 7, 0, 0);
    cycle(0, 0, 0, 0, 1, 20);
    if (FWD) begin
      check("fwd_hit", 32'(s_hit), 1);
      check("fwd_data", s_ld_data, 7);
      check("fwd_no_stall", 32'(s_stall), 0);
    end else begin
      check("conf_stall", 32'(s_stall), 1);
      cycle(0, 0, 0, 0, 1, 20);
      check("conf_data", s_ld_data, 7);
      check("conf_released", 32'(s_stall), 0);
    end
    drain_all();

    // youngest wins
    cycle(0, 1, 20, 9, 1, 12);
    cycle(0, 1, 20, 11, 1, 12);
    done = 1'b0;
    for (int k = 0; k < DEPTH + 2 && !done; k++) begin
      cycle(0, 0, 0, 0, 1, 20);
      done = !s_stall;
    end
    check("youngest_settled", 32'(done), 1);
    check("youngest_data", s_ld_data, 11);
    drain_all();

    // full buffer
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 32'(16 + 4 * i), 32'(200 + i), 1, 12);
    cycle(0, 1, 40, 250, 0, 0);
    check("full_count", 32'(s_count), 4);
    check("full_stall", 32'(s_stall), 1);
    check("full_drain", 32'(s_mw), 1);
    cycle(0, 1, 40, 250, 0, 0);
    check("full_accept", 32'(s_stall), 0);
    drain_all();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 2)       cycle(1, 0, 0, 0, 0, rand_addr());
      else if (op < 12) cycle(0, 1, rand_addr(), $urandom(), 1, rand_addr());
      else if (op < 50) cycle(0, 1, rand_addr(), $urandom(), 0, 0);
      else if (op < 88) cycle(0, 0, 0, 0, 1, rand_addr());
      else              cycle(0, 0, 0, 0, 0, rand_addr());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
